// File: rtl/trigger_event_collector_if.sv
// Bus between the device-event side and the trigger collector.
// The master drives the event lines, the capture mask and the overflow clear.
// The slave (the collector) returns the trigger byte and its status.
interface trigger_event_collector_if;
  logic [7:0] event_in;
  logic [7:0] event_mask;
  logic       overflow_clr;
  logic [7:0] trigger_to_host;
  logic       busy;
  logic [7:0] overflow;

  modport master (
    output event_in,
    output event_mask,
    output overflow_clr,
    input  trigger_to_host,
    input  busy,
    input  overflow
  );

  modport slave (
    input  event_in,
    input  event_mask,
    input  overflow_clr,
    output trigger_to_host,
    output busy,
    output overflow
  );
endinterface

// File: rtl/trigger_event_collector.sv
// Trigger event collector.
// Synchronises 8 asynchronous event lines and detects their rising edges.
// Each captured byte is presented to the host-trigger stage in three phases:
//   - it is held for HOLD_CYCLES,
//   - the output is then forced to zero for GAP_CYCLES,
//   - the block then spends at least one cycle in IDLE.
// Edges that arrive while a byte is in flight collect in a pending register
// and go out in the next slot.
module trigger_event_collector #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 12
) (
  input  logic                        uc_clk,
  input  logic                        uc_reset,
  trigger_event_collector_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  state_t     state, state_nxt;
  logic [7:0] sync_p [SYNC_STAGES];
  logic [7:0] prev_q;
  logic [7:0] rise;
  logic [7:0] pending_q, pending_nxt;
  logic [7:0] out_q, out_nxt;
  logic [7:0] cnt_q, cnt_nxt;
  logic [7:0] overflow_q, overflow_nxt;
  logic [7:0] ovf_set;
  logic       busy_q;

  // Rising edge of a synchronised, enabled line; prev starts at 0 so a line
  // already high when reset is released still counts once.
  assign rise = sync_p[SYNC_STAGES-1] & ~prev_q & bus.event_mask;

  // Synchroniser chain and previous-sample register for edge detection.
  always_ff @(posedge uc_clk or negedge uc_reset) begin
    if (!uc_reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_p[0] <= bus.event_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
      prev_q <= sync_p[SYNC_STAGES-1];
    end
  end

  // Slot sequencing: next state, held byte, pending accumulation, overflow.
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending_q;
    out_nxt     = out_q;
    cnt_nxt     = cnt_q;
    ovf_set     = '0;
    case (state)
      IDLE: begin
        if ((pending_q | rise) != 8'h00) begin
          out_nxt     = pending_q | rise;
          pending_nxt = '0;
          cnt_nxt     = 8'(HOLD_CYCLES - 1);
          state_nxt   = HOLD;
        end
      end
      HOLD: begin
        // A bit already on the bus is free to queue again; only a second
        // edge on an already-pending bit is lost.
        ovf_set     = rise & pending_q;
        pending_nxt = pending_q | rise;
        if (cnt_q == 8'd0) begin
          out_nxt   = '0;
          cnt_nxt   = 8'(GAP_CYCLES - 1);
          state_nxt = GAP;
        end else begin
          cnt_nxt = cnt_q - 8'd1;
        end
      end
      GAP: begin
        // Always pass through IDLE so the downstream sees a full zero gap.
        ovf_set     = rise & pending_q;
        pending_nxt = pending_q | rise;
        if (cnt_q == 8'd0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt_q - 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        out_nxt   = '0;
        cnt_nxt   = '0;
      end
    endcase
    // A new overflow in the same cycle as a clear survives the clear.
    overflow_nxt = (bus.overflow_clr ? 8'h00 : overflow_q) | ovf_set;
  end

  // State and datapath registers; busy is registered from the next state.
  always_ff @(posedge uc_clk or negedge uc_reset) begin
    if (!uc_reset) begin
      state      <= IDLE;
      pending_q  <= '0;
      out_q      <= '0;
      cnt_q      <= '0;
      overflow_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      pending_q  <= pending_nxt;
      out_q      <= out_nxt;
      cnt_q      <= cnt_nxt;
      overflow_q <= overflow_nxt;
      busy_q     <= (state_nxt != IDLE);
    end
  end

  assign bus.trigger_to_host = out_q;
  assign bus.busy            = busy_q;
  assign bus.overflow        = overflow_q;

endmodule
